// File: rtl/pixel_scan_writer_pkg.sv
// Shared definitions for the pixel scan writer: screen defaults, coordinate
// and framebuffer address widths, and the frame-render state encoding.
package pixel_scan_writer_pkg;

   localparam int DEF_SCREEN_WIDTH  = 640;
   localparam int DEF_SCREEN_HEIGHT = 480;
   localparam int CORDW             = 10;
   localparam int ADDRW             = 19;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/pixel_delay_line.sv
// Fixed-depth shift line that carries a valid flag and a payload alongside the
// raymarcher pipeline. Only the valid flags are reset; the payload is
// qualified by its valid and is free-running.
module pixel_delay_line #(
   parameter int STAGES = 4,
   parameter int DATA_W = 19
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_vld,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_vld,
   output logic [DATA_W-1:0] out_data
);

   logic [STAGES-1:0] vld_p;
   logic [DATA_W-1:0] data_p [STAGES];

   // Shift the valid flags one stage per cycle; reset empties the line.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= in_vld;
         for (int i = 1; i < STAGES; i++) begin
            vld_p[i] <= vld_p[i-1];
         end
      end
   end

   // Shift the payload in lockstep with its valid flag.
   always_ff @(posedge clk) begin
      data_p[0] <= in_data;
      for (int i = 1; i < STAGES; i++) begin
         data_p[i] <= data_p[i-1];
      end
   end

   assign out_vld  = vld_p[STAGES-1];
   assign out_data = data_p[STAGES-1];

endmodule

// File: rtl/pixel_scan_writer.sv
// Raster-scan frame writer: issues pixel coordinates to a raymarcher one per
// cycle, waits PIPE_LATENCY cycles for the colour, and writes the packed
// RGB332 value to the framebuffer SRAM at y*SCREEN_WIDTH + x.
// Optional feature: define FRAME_COUNT_EN to add a 16-bit frame_count output
// that increments once per completed frame.
module pixel_scan_writer
   import pixel_scan_writer_pkg::*;
#(
   parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
   parameter int PIPE_LATENCY  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [CORDW-1:0] pixel_x,
   output logic [CORDW-1:0] pixel_y,
   input  logic [7:0]       red,
   input  logic [7:0]       green,
   input  logic [7:0]       blue,
   output logic             sram_we,
   output logic [ADDRW-1:0] sram_addr,
   output logic [7:0]       sram_data
`ifdef FRAME_COUNT_EN
   ,
   output logic [15:0]      frame_count
`endif
);

   localparam logic [CORDW-1:0] X_LAST    = CORDW'(SCREEN_WIDTH - 1);
   localparam logic [CORDW-1:0] Y_LAST    = CORDW'(SCREEN_HEIGHT - 1);
   localparam logic [ADDRW-1:0] ADDR_LAST = ADDRW'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);

   // Keep the top colour bits only: RRRGGGBB.
   function automatic logic [7:0] pack_rgb332(input logic [2:0] r3,
                                              input logic [2:0] g3,
                                              input logic [1:0] b2);
      return {r3, g3, b2};
   endfunction

   state_t           state;
   logic [ADDRW-1:0] addr_cnt;
   logic             issue_vld;
   logic             line_vld;
   logic [ADDRW-1:0] line_addr;
   logic             unused_colour_bits;

   // The truncated low colour bits are intentionally discarded.
   assign unused_colour_bits = ^{red[4:0], green[4:0], blue[5:0]};

   // A pixel is issued on every SCAN cycle; addr_cnt tracks y*W+x of it.
   assign issue_vld = (state == SCAN);

   // Frame sequencer: raster scan, wait for the pipeline to drain, pulse done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         pixel_x  <= '0;
         pixel_y  <= '0;
         addr_cnt <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state    <= SCAN;
                  busy     <= 1'b1;
                  pixel_x  <= '0;
                  pixel_y  <= '0;
                  addr_cnt <= '0;
               end
            end
            SCAN: begin
               if (pixel_x == X_LAST) begin
                  if (pixel_y == Y_LAST) begin
                     // Last coordinate stays on the bus while the line drains.
                     state <= DRAIN;
                  end else begin
                     pixel_x  <= '0;
                     pixel_y  <= pixel_y + 1'b1;
                     addr_cnt <= addr_cnt + 1'b1;
                  end
               end else begin
                  pixel_x  <= pixel_x + 1'b1;
                  addr_cnt <= addr_cnt + 1'b1;
               end
            end
            DRAIN: begin
               if (line_vld && (line_addr == ADDR_LAST)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state   <= IDLE;
               busy    <= 1'b0;
               pixel_x <= '0;
               pixel_y <= '0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   pixel_delay_line #(
      .STAGES (PIPE_LATENCY),
      .DATA_W (ADDRW)
   ) u_line (
      .clk      (clk),
      .reset    (reset),
      .in_vld   (issue_vld),
      .in_data  (addr_cnt),
      .out_vld  (line_vld),
      .out_data (line_addr)
   );

   // Write stage: colour arrives in the same cycle the entry leaves the line;
   // address and data are forced to zero when no write is in progress.
   always_comb begin
      sram_we   = line_vld;
      sram_addr = '0;
      sram_data = '0;
      if (line_vld) begin
         sram_addr = line_addr;
         sram_data = pack_rgb332(red[7:5], green[7:5], blue[7:6]);
      end
   end

`ifdef FRAME_COUNT_EN
   // Count completed frames; wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_count <= '0;
      end else if (state == DONE) begin
         frame_count <= frame_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pixel_scan_writer.sv
// Directed bench for pixel_scan_writer. Instance A uses a 640-wide, 4-row
// screen (keeps a full frame short while preserving the row stride);
// instance B uses a 4x2 screen with PIPE_LATENCY=3.
module tb_pixel_scan_writer;

   localparam int AW = 640;
   localparam int AH = 4;
   localparam int NA = AW * AH;
   localparam int LA = 4;
   localparam int BW = 4;
   localparam int BH = 2;
   localparam int NB = BW * BH;
   localparam int LB = 3;

   logic clk = 1'b0;
   logic reset;
   logic a_start, b_start;

   logic        a_busy, a_done, a_we;
   logic [9:0]  a_px, a_py;
   logic [7:0]  a_red, a_green, a_blue, a_data;
   logic [18:0] a_addr;

   logic        b_busy, b_done, b_we;
   logic [9:0]  b_px, b_py;
   logic [7:0]  b_red, b_green, b_blue, b_data;
   logic [18:0] b_addr;

`ifdef FRAME_COUNT_EN
   logic [15:0] a_fc, b_fc;
`endif

   int total, bad;
   int a_mode;
   int a_wcnt, a_addr_err, a_data_err, a_idle_err, a_done_cnt;
   logic [18:0] a_next;
   logic [7:0]  a_red641, a_data641;
   int b_data_err, b_idle_err;
   logic [18:0] b_q[$];

   always #5 clk = ~clk;

   pixel_scan_writer #(.SCREEN_WIDTH(AW), .SCREEN_HEIGHT(AH), .PIPE_LATENCY(LA)) dut_a (
      .clk(clk), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done),
      .pixel_x(a_px), .pixel_y(a_py), .red(a_red), .green(a_green), .blue(a_blue),
      .sram_we(a_we), .sram_addr(a_addr), .sram_data(a_data)
`ifdef FRAME_COUNT_EN
      , .frame_count(a_fc)
`endif
   );

   pixel_scan_writer #(.SCREEN_WIDTH(BW), .SCREEN_HEIGHT(BH), .PIPE_LATENCY(LB)) dut_b (
      .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
      .pixel_x(b_px), .pixel_y(b_py), .red(b_red), .green(b_green), .blue(b_blue),
      .sram_we(b_we), .sram_addr(b_addr), .sram_data(b_data)
`ifdef FRAME_COUNT_EN
      , .frame_count(b_fc)
`endif
   );

   // Raymarcher stand-in for A: mode 1 returns red = pixel_x[7:0] LA cycles later.
   logic [9:0] rm [LA];
   always @(posedge clk) begin
      rm[0] <= a_px;
      for (int i = 1; i < LA; i++) rm[i] <= rm[i-1];
   end
   // Mode 0 colours: {111, 110, 11} -> 0xFB; green low bits 0x1C are dropped.
   assign a_red   = (a_mode == 1) ? rm[LA-1][7:0] : 8'hE0;
   assign a_green = (a_mode == 1) ? 8'h00 : 8'hDC;
   assign a_blue  = (a_mode == 1) ? 8'h00 : 8'hC0;
   // B colours: {111, 000, 01} -> 0xE1.
   assign b_red   = 8'hFF;
   assign b_green = 8'h00;
   assign b_blue  = 8'h40;

   // Write monitor for A.
   always @(negedge clk) begin
      if (a_we) begin
         a_wcnt++;
         if (a_addr !== a_next) a_addr_err++;
         a_next = a_addr + 19'd1;
         if (a_mode == 0) begin
            if (a_data !== 8'hFB) a_data_err++;
         end else begin
            if (a_red !== 8'(int'(a_addr) % AW)) a_data_err++;
            if (a_data !== {a_red[7:5], 5'b00000}) a_data_err++;
            if (a_addr == 19'd641) begin
               a_red641  = a_red;
               a_data641 = a_data;
            end
         end
      end else if (a_addr !== 19'd0 || a_data !== 8'd0) begin
         a_idle_err++;
      end
      if (a_done) a_done_cnt++;
   end

   // Write monitor for B.
   always @(negedge clk) begin
      if (b_we) begin
         b_q.push_back(b_addr);
         if (b_data !== 8'hE1) b_data_err++;
      end else if (b_addr !== 19'd0 || b_data !== 8'd0) begin
         b_idle_err++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_a();
      a_wcnt = 0; a_addr_err = 0; a_data_err = 0; a_idle_err = 0; a_done_cnt = 0;
      a_next = '0; a_red641 = 8'hFF; a_data641 = 8'hFF;
   endtask

   // Start a frame on A (call just after a negedge); k counts negedges after acceptance.
   task automatic run_frame_a(input int mid_k, output int first_k, output int first_addr,
                              output int done_k);
      first_k = -1; first_addr = -1; done_k = -1;
      a_start = 1'b1;
      for (int k = 1; k <= NA + 50; k++) begin
         @(negedge clk);
         a_start = (k == mid_k);
         if (a_we && first_k < 0) begin
            first_k    = k;
            first_addr = int'(a_addr);
         end
         if (a_done) begin
            done_k = k;
            break;
         end
      end
      a_start = 1'b0;
      #1;
   endtask

   initial begin
      int fk, fa, dk, hit, seq_err;
      total = 0; bad = 0;
      reset = 1'b1; a_start = 1'b0; b_start = 1'b0; a_mode = 0;
      clear_a();
      b_data_err = 0; b_idle_err = 0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(a_busy), 32'd0);
      check("rst_done", 32'(a_done), 32'd0);
      check("rst_px", 32'(a_px), 32'd0);
      check("rst_py", 32'(a_py), 32'd0);
      check("rst_we", 32'(a_we), 32'd0);
      check("rst_addr", 32'(a_addr), 32'd0);
      check("rst_data", 32'(a_data), 32'd0);
      check("rst_b_busy", 32'(b_busy), 32'd0);
`ifdef FRAME_COUNT_EN
      check("rst_fc", 32'(b_fc), 32'd0);
`endif
      reset = 1'b0;
      @(negedge clk);
      #1;

      // Frame 1: constant colours
      clear_a();
      run_frame_a(0, fk, fa, dk);
      check("f1_first_we_k", 32'(fk), 32'(LA + 1));
      check("f1_first_addr", 32'(fa), 32'd0);
      check("f1_done_k", 32'(dk), 32'(NA + LA + 1));
      check("f1_busy_in_done", 32'(a_busy), 32'd1);
      check("f1_writes", 32'(a_wcnt), 32'(NA));
      check("f1_addr_err", 32'(a_addr_err), 32'd0);
      check("f1_data_err", 32'(a_data_err), 32'd0);
      check("f1_idle_err", 32'(a_idle_err), 32'd0);
      @(negedge clk);
      #1;
      check("f1_idle_busy", 32'(a_busy), 32'd0);
      check("f1_idle_done", 32'(a_done), 32'd0);

      // Frame 2: red ramp, start pulsed mid-frame
      a_mode = 1;
      clear_a();
      run_frame_a(NA / 2, fk, fa, dk);
      check("f2_done_k", 32'(dk), 32'(NA + LA + 1));
      check("f2_writes", 32'(a_wcnt), 32'(NA));
      check("f2_addr_err", 32'(a_addr_err), 32'd0);
      check("f2_data_err", 32'(a_data_err), 32'd0);
      check("f2_red_641", 32'(a_red641), 32'd1);
      check("f2_data641_r", 32'(a_data641[7:5]), 32'd0);
      repeat (3) @(negedge clk);
      #1;
      check("f2_done_pulses", 32'(a_done_cnt), 32'd1);
      check("f2_idle_busy", 32'(a_busy), 32'd0);

      // Frame 3: reset (with start) at pixel 1000
      a_mode = 0;
      clear_a();
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      hit = 0;
      for (int i = 0; i < NA; i++) begin
         @(negedge clk);
         if (a_we && a_addr == 19'd1000) begin
            hit = 1;
            break;
         end
      end
      check("f3_reached_1000", 32'(hit), 32'd1);
      reset = 1'b1;
      a_start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      a_start = 1'b0;
      check("f3_we_after_rst", 32'(a_we), 32'd0);
      check("f3_busy_after_rst", 32'(a_busy), 32'd0);
      check("f3_px_after_rst", 32'(a_px), 32'd0);
      check("f3_py_after_rst", 32'(a_py), 32'd0);
      repeat (20) @(negedge clk);
      #1;
      check("f3_writes_total", 32'(a_wcnt), 32'd1001);
      check("f3_still_idle", 32'(a_busy), 32'd0);

      // Frame 4: full frame after the abort
      clear_a();
      run_frame_a(0, fk, fa, dk);
      check("f4_first_we_k", 32'(fk), 32'(LA + 1));
      check("f4_first_addr", 32'(fa), 32'd0);
      check("f4_done_k", 32'(dk), 32'(NA + LA + 1));
      check("f4_writes", 32'(a_wcnt), 32'(NA));
      check("f4_addr_err", 32'(a_addr_err), 32'd0);
      @(negedge clk);
      #1;

      // Instance B: two frames, start in DONE ignored, start in first IDLE accepted
      b_q.delete();
      b_start = 1'b1;
      dk = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         b_start = 1'b0;
         if (b_done) begin
            dk = k;
            break;
         end
      end
      check("b1_done_k", 32'(dk), 32'(NB + LB + 1));
      b_start = 1'b1;
      @(negedge clk);
      #1;
      check("b_start_in_done", 32'(b_busy), 32'd0);
      @(negedge clk);
      b_start = 1'b0;
      #1;
      check("b_start_first_idle", 32'(b_busy), 32'd1);
      dk = -1;
      for (int k = 2; k <= 60; k++) begin
         @(negedge clk);
         if (b_done) begin
            dk = k;
            break;
         end
      end
      check("b2_done_k", 32'(dk), 32'(NB + LB + 1));
      repeat (3) @(negedge clk);
      #1;
      check("b_write_count", 32'(b_q.size()), 32'(2 * NB));
      seq_err = 0;
      foreach (b_q[i]) if (b_q[i] !== 19'(i % NB)) seq_err++;
      check("b_addr_order", 32'(seq_err), 32'd0);
      check("b_data_err", 32'(b_data_err), 32'd0);
      check("b_idle_err", 32'(b_idle_err), 32'd0);
`ifdef FRAME_COUNT_EN
      check("b_frame_count", 32'(b_fc), 32'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
